// File: rtl/mul_seq_ctrl.sv
// Multicycle sequencer around a combinational radix-4 Booth multiplier.
// Operands are latched on start, held for SETTLE_CYCLES edges, and the product is captured into HI/LO.

module booth (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] z
);
    logic signed [63:0] a_ext;
    logic        [32:0] b_pad;
    logic signed [63:0] pp;
    logic signed [63:0] acc;

    assign a_ext = {{32{a[31]}}, a};
    assign b_pad = {b, 1'b0};

    // Sixteen radix-4 digits, each selecting 0, +-a or +-2a
    always_comb begin
        acc = '0;
        pp  = '0;
        for (int i = 0; i < 16; i++) begin
            case (b_pad[2*i +: 3])
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext <<< 1;
                3'b100:         pp = -(a_ext <<< 1);
                3'b101, 3'b110: pp = -a_ext;
                default:        pp = '0;
            endcase
            acc = acc + (pp <<< (2 * i));
        end
    end

    assign z = acc;
endmodule

module mul_seq_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        ovf
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             load_ops;
    logic             capture;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [63:0]      z;

    // Booth sees only the held operands, making it a legal multicycle path
    booth u_booth (
        .a (op_a),
        .b (op_b),
        .z (z)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Abort outranks capture on the final settle edge
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_ops  = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = '0;
                    load_ops  = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_DONE;
                    capture   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Operands, status flags and result registers
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            op_a   <= '0;
            op_b   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi_out <= '0;
            lo_out <= '0;
            ovf    <= 1'b0;
        end else begin
            busy <= (state_nxt == ST_SETTLE);
            done <= (state_nxt == ST_DONE);
            if (load_ops) begin
                op_a <= a_in;
                op_b <= b_in;
            end
            if (capture) begin
                hi_out <= z[63:32];
                lo_out <= z[31:0];
                ovf    <= ~((&z[63:31]) | ~(|z[63:31]));
            end
        end
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed literal checks plus a randomized run
// compared every cycle against a cycle-count/arithmetic model.

module tb_mul_seq_ctrl;
    localparam int SETTLE = 2;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] a_in  = '0;
    logic [31:0] b_in  = '0;
    logic        busy, done, ovf;
    logic [31:0] hi_out, lo_out;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    // Model: cycles left in the settle window, pending product, and visible outputs
    int          m_rem  = 0;
    bit          m_done = 0;
    longint      m_pend = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    bit          m_ovf  = 0;

    mul_seq_ctrl #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
        .clock  (clock),
        .clear  (clear),
        .start  (start),
        .abort  (abort),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .hi_out (hi_out),
        .lo_out (lo_out),
        .ovf    (ovf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic s, input logic ab, input logic [31:0] a, input logic [31:0] b);
        m_done = 0;
        if (m_rem > 0) begin
            if (ab) begin
                m_rem = 0;
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_hi   = m_pend[63:32];
                    m_lo   = m_pend[31:0];
                    m_ovf  = (m_pend != longint'($signed(m_pend[31:0])));
                    m_done = 1;
                end
            end
        end else if (s) begin
            m_pend = longint'($signed(a)) * longint'($signed(b));
            m_rem  = SETTLE;
        end
    endtask

    // Model update and per-cycle compare
    initial begin
        forever begin
            @(posedge clock or posedge clear);
            if (clear) begin
                m_rem = 0; m_done = 0; m_pend = 0;
                m_hi = '0; m_lo = '0; m_ovf = 0;
            end else begin
                model_edge(start, abort, a_in, b_in);
                #1;
                if (chk_en) begin
                    chk("cyc_busy", 64'(busy), 64'(m_rem > 0));
                    chk("cyc_done", 64'(done), 64'(m_done));
                    chk("cyc_hi",   64'(hi_out), 64'(m_hi));
                    chk("cyc_lo",   64'(lo_out), 64'(m_lo));
                    chk("cyc_ovf",  64'(ovf), 64'(m_ovf));
                end
            end
        end
    end

    task automatic step(input logic s, input logic ab, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start = s; abort = ab; a_in = a; b_in = b;
    endtask

    task automatic run_mul(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input logic eovf);
        step(1, 0, a, b);
        step(0, 0, 32'hDEAD_BEEF, 32'h1234_5678);
        chk({nm, "_busy1"}, 64'(busy), 64'd1);
        step(0, 0, 0, 0);
        chk({nm, "_busy2"}, 64'(busy), 64'd1);
        chk({nm, "_nodone"}, 64'(done), 64'd0);
        step(0, 0, 0, 0);
        chk({nm, "_done"}, 64'(done), 64'd1);
        chk({nm, "_busy0"}, 64'(busy), 64'd0);
        chk({nm, "_hi"}, 64'(hi_out), 64'(ehi));
        chk({nm, "_lo"}, 64'(lo_out), 64'(elo));
        chk({nm, "_ovf"}, 64'(ovf), 64'(eovf));
        step(0, 0, 0, 0);
        chk({nm, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0;
            4: return 32'($urandom_range(0, 100));
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] pa [3];
    logic [31:0] pb [3];
    logic [31:0] ph [3];
    logic [31:0] pl [3];

    initial begin
        pa[0] = 32'd3;         pb[0] = 32'd4; ph[0] = 32'h0;         pl[0] = 32'd12;
        pa[1] = 32'hFFFF_FFFE; pb[1] = 32'd6; ph[1] = 32'hFFFF_FFFF; pl[1] = 32'hFFFF_FFF4;
        pa[2] = 32'd0;         pb[2] = 32'd9; ph[2] = 32'h0;         pl[2] = 32'h0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi_out), 64'd0);
        chk("rst_lo", 64'(lo_out), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        clear  = 1'b0;
        chk_en = 1;

        run_mul("neg3", 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_mul("minmin", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b1);
        run_mul("maxx2", 32'h7FFF_FFFF, 32'd2, 32'h0, 32'hFFFF_FFFE, 1'b1);

        // Back-to-back with start held; operands scrambled mid-settle
        for (int k = 0; k <= 9; k++) begin
            if (k <= 6 && k % 3 == 0) step(1, 0, pa[k/3], pb[k/3]);
            else step(k <= 6, 0, $urandom, $urandom);
            if (k >= 3 && k % 3 == 0) begin
                chk("b2b_done", 64'(done), 64'd1);
                chk("b2b_hi", 64'(hi_out), 64'(ph[k/3-1]));
                chk("b2b_lo", 64'(lo_out), 64'(pl[k/3-1]));
            end else if (k >= 1) begin
                chk("b2b_nodone", 64'(done), 64'd0);
            end
        end
        step(0, 0, 0, 0);

        // Abort one edge into the settle window
        run_mul("six7", 32'd6, 32'd7, 32'h0, 32'd42, 1'b0);
        step(1, 0, 32'd100, 32'd100);
        step(0, 1, 32'd100, 32'd100);
        chk("abt_busy_before", 64'(busy), 64'd1);
        step(0, 0, 0, 0);
        chk("abt_busy", 64'(busy), 64'd0);
        for (int k = 0; k < 4; k++) begin
            chk("abt_nodone", 64'(done), 64'd0);
            chk("abt_lo", 64'(lo_out), 64'd42);
            chk("abt_hi", 64'(hi_out), 64'd0);
            step(0, 0, 0, 0);
        end

        // Asynchronous clear mid-settle
        step(1, 0, 32'd5, 32'd5);
        step(0, 0, 0, 0);
        chk("clr_pre_busy", 64'(busy), 64'd1);
        #2 clear = 1'b1;
        #1;
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_done", 64'(done), 64'd0);
        chk("clr_lo", 64'(lo_out), 64'd0);
        chk("clr_hi", 64'(hi_out), 64'd0);
        chk("clr_ovf", 64'(ovf), 64'd0);
        #1 clear = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0);
            chk("clr_nodone", 64'(done), 64'd0);
            chk("clr_idle", 64'(busy), 64'd0);
        end

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 1, pick(), pick());
        end
        step(0, 0, 0, 0);
        repeat (4) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
